ofmap_writeback: RTL

Output writeback stage sitting directly downstream of the accelerator top level. It consumes the serial 16-bit ofmap stream (`o_ofmap` / `o_ofmap_valid` / `o_done` of the top level) and packs consecutive results into 64-bit words. It writes those words into a local output scratchpad starting at a host-programmed address and exposes a read port so the host can drain results after a layer completes. It flushes partial words on layer completion and reports word count and overflow.

---
 rtl/ofmap_writeback_if.sv | 34 +++
 rtl/ofmap_writeback.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ofmap_writeback_if.sv
// Host/stream-side bundle of the ofmap writeback stage.
// The slave modport is the DUT view; the master modport drives it.
interface ofmap_writeback_if #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned SRAM_DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH      = 8
);
  logic                       i_reg_clear;
  logic                       i_start;
  logic [ADDR_WIDTH-1:0]      i_start_addr;
  logic [DATA_WIDTH-1:0]      i_ofmap;
  logic                       i_ofmap_valid;
  logic                       i_done;
  logic                       i_read_en;
  logic [ADDR_WIDTH-1:0]      i_read_addr;
  logic [SRAM_DATA_WIDTH-1:0] o_read_data;
  logic                       o_read_valid;
  logic                       o_busy;
  logic                       o_done;
  logic [ADDR_WIDTH:0]        o_word_count;
  logic                       o_overflow;

  modport slave (
    input  i_reg_clear, i_start, i_start_addr, i_ofmap, i_ofmap_valid, i_done,
           i_read_en, i_read_addr,
    output o_read_data, o_read_valid, o_busy, o_done, o_word_count, o_overflow
  );

  modport master (
    output i_reg_clear, i_start, i_start_addr, i_ofmap, i_ofmap_valid, i_done,
           i_read_en, i_read_addr,
    input  o_read_data, o_read_valid, o_busy, o_done, o_word_count, o_overflow
  );
endinterface

// File: rtl/ofmap_writeback.sv
// Packs the serial ofmap stream into SRAM-width words, stores them in a local
// scratchpad from a programmed base address, and serves host reads.
module ofmap_writeback #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned SRAM_DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned DEPTH           = 256
) (
  input logic            i_clk,
  input logic            i_rst,
  ofmap_writeback_if.slave bus
);

  localparam int unsigned LANES  = SRAM_DATA_WIDTH / DATA_WIDTH;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(LANES - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StActive = 2'd1;
  localparam logic [1:0] StFlush  = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [ADDR_WIDTH:0]        wptr_q, wptr_d;
  logic [LANE_W-1:0]          lane_q, lane_d;
  logic [SRAM_DATA_WIDTH-1:0] hold_q, hold_d;
  logic [ADDR_WIDTH:0]        count_q, count_d;
  logic                       ovf_q, ovf_d;
  logic [SRAM_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                       rd_valid_q, rd_valid_d;
  logic                       clear;
  logic                       wr_req, wr_en;
  logic [SRAM_DATA_WIDTH-1:0] wr_data;
  logic [SRAM_DATA_WIDTH-1:0] mem_q [DEPTH];

  assign clear = i_rst | bus.i_reg_clear;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    lane_d  = lane_q;
    hold_d  = hold_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    wr_req  = 1'b0;
    wr_en   = 1'b0;
    wr_data = hold_q;
    unique case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          state_d = StActive;
          wptr_d  = {1'b0, bus.i_start_addr};
          lane_d  = '0;
          hold_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      StActive: begin
        if (bus.i_ofmap_valid) begin
          for (int unsigned k = 0; k < LANES; k++) begin
            if (lane_q == LANE_W'(k)) wr_data[k*DATA_WIDTH +: DATA_WIDTH] = bus.i_ofmap;
          end
          if (lane_q == LAST_LANE) begin
            wr_req = 1'b1;
            lane_d = '0;
            hold_d = '0;
          end else begin
            lane_d = lane_q + LANE_W'(1);
            hold_d = wr_data;
          end
        end
        if (bus.i_done) state_d = StFlush;
      end
      StFlush: begin
        // hold_q is zero above the filled lanes, so it is already padded
        if (lane_q != '0) wr_req = 1'b1;
        lane_d  = '0;
        hold_d  = '0;
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Writes past the scratchpad are dropped without moving the pointer.
    if (wr_req && !clear) begin
      if (wptr_q < DEPTH_W) begin
        wr_en   = 1'b1;
        wptr_d  = wptr_q + 1'b1;
        count_d = count_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_comb begin
    rd_valid_d = bus.i_read_en;
    rd_data_d  = rd_data_q;
    if (bus.i_read_en) begin
      rd_data_d = ({1'b0, bus.i_read_addr} < DEPTH_W) ? mem_q[bus.i_read_addr] : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (clear) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      lane_q     <= '0;
      hold_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      lane_q     <= lane_d;
      hold_q     <= hold_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Scratchpad survives reset by design.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wptr_q[ADDR_WIDTH-1:0]] <= wr_data;
  end

  assign bus.o_read_data  = rd_data_q;
  assign bus.o_read_valid = rd_valid_q;
  assign bus.o_busy       = (state_q == StActive) || (state_q == StFlush);
  assign bus.o_done       = (state_q == StDone);
  assign bus.o_word_count = count_q;
  assign bus.o_overflow   = ovf_q;

endmodule
